keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with per-key debounce.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat key_valid pulses while a key stays pressed.
module keypad_scanner #(
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // An out-of-range configuration degrades to single-sample acceptance.
  localparam logic [3:0] DEB_N =
    (DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT < 1) ? 4'd1 : 4'(DEBOUNCE);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
`endif

  logic [3:0]       row_meta_reg, row_sync_reg;
  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [1:0]       row_idx_reg, row_idx_next;
  logic [3:0]       match_cnt_reg, match_cnt_next;
  logic [3:0]       rel_cnt_reg, rel_cnt_next;
  logic [3:0]       key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_held_reg, key_held_next;
  logic             sample_pt;
  logic             accept;
  logic [1:0]       accept_row;
  logic [1:0]       low_row;

  assign sample_pt = (div_cnt_reg == DIV_LAST);

  // Exactly one column driven low, selected by the column index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col[gi] = (col_idx_reg != 2'(gi));
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_reg[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = sample_pt ? '0 : div_cnt_reg + 1'b1;
    col_idx_next   = col_idx_reg;
    row_idx_next   = row_idx_reg;
    match_cnt_next = match_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
    accept         = 1'b0;
    accept_row     = row_idx_reg;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
`endif
    if (sample_pt) begin
      unique case (state_reg)
        SCAN: begin
          if (row_sync_reg != 4'hF) begin
            row_idx_next   = low_row;
            accept_row     = low_row;
            match_cnt_next = 4'd1;
            if (DEB_N == 4'd1) accept = 1'b1;
            else               state_next = CONFIRM;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
        CONFIRM: begin
          if (!row_sync_reg[row_idx_reg]) begin
            match_cnt_next = match_cnt_reg + 4'd1;
            if (match_cnt_reg + 4'd1 == DEB_N) accept = 1'b1;
          end else begin
            state_next     = SCAN;
            match_cnt_next = '0;
            col_idx_next   = col_idx_reg + 2'd1;
          end
        end
        HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_cnt_reg == REP_LAST) begin
            rep_cnt_next   = '0;
            key_valid_next = !row_sync_reg[row_idx_reg];
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
`endif
          if (row_sync_reg[row_idx_reg]) begin
            if (rel_cnt_reg + 4'd1 == DEB_N) begin
              state_next    = SCAN;
              key_held_next = 1'b0;
              rel_cnt_next  = '0;
              col_idx_next  = col_idx_reg + 2'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_next  = '0;
`endif
            end else begin
              rel_cnt_next = rel_cnt_reg + 4'd1;
            end
          end else begin
            rel_cnt_next = '0;
          end
        end
        default: state_next = SCAN;
      endcase

      if (accept) begin
        state_next     = HELD;
        key_code_next  = {accept_row, col_idx_reg};
        key_valid_next = 1'b1;
        key_held_next  = 1'b1;
        match_cnt_next = '0;
        rel_cnt_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_next   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta_reg  <= 4'hF;
      row_sync_reg  <= 4'hF;
      state_reg     <= SCAN;
      div_cnt_reg   <= '0;
      col_idx_reg   <= 2'd0;
      row_idx_reg   <= 2'd0;
      match_cnt_reg <= '0;
      rel_cnt_reg   <= '0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg   <= '0;
`endif
    end else begin
      row_meta_reg  <= row;
      row_sync_reg  <= row_meta_reg;
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      col_idx_reg   <= col_idx_next;
      row_idx_reg   <= row_idx_next;
      match_cnt_reg <= match_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg   <= rep_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad and checks keypad_scanner every cycle
// against a sample-point-level behavioural model, plus directed literal scenarios.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RP = 5;
  localparam int M_SCAN = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  bit live = 0;

  // Model state: synchronizer history, dwell phase, column, debounce progress, outputs.
  logic [3:0] m_hist0, m_hist1;
  int m_phase, m_col, m_mode, m_kr, m_kc, m_streak, m_rel, m_code;
  bit m_valid, m_held;
`ifdef KEYPAD_AUTOREPEAT_EN
  int m_rep;
`endif

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT(RP)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_accept();
    m_code  = m_kr * 4 + m_kc;
    m_valid = 1;
    m_held  = 1;
    m_mode  = M_HELD;
    m_rel   = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    m_rep   = 0;
`endif
  endtask

  task automatic model_edge();
    logic [3:0] rs;
    int low;
    if (rst !== 1'b1) begin
      m_hist0 = 4'hF; m_hist1 = 4'hF; m_phase = 0; m_col = 0; m_mode = M_SCAN;
      m_streak = 0; m_rel = 0; m_code = 0; m_valid = 0; m_held = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      m_rep = 0;
`endif
      return;
    end
    rs = m_hist1;
    m_hist1 = m_hist0;
    m_hist0 = row;
    m_valid = 0;
    if (m_phase != SD - 1) begin
      m_phase++;
      return;
    end
    m_phase = 0;
    case (m_mode)
      M_SCAN: begin
        if (rs != 4'hF) begin
          low = 0;
          for (int r = 3; r >= 0; r--) if (!rs[r]) low = r;
          m_kr = low; m_kc = m_col; m_streak = 1;
          if (m_streak >= DB) model_accept(); else m_mode = M_CONFIRM;
        end else m_col = (m_col + 1) % 4;
      end
      M_CONFIRM: begin
        if (!rs[m_kr]) begin
          m_streak++;
          if (m_streak >= DB) model_accept();
        end else begin
          m_mode = M_SCAN;
          m_col = (m_col + 1) % 4;
        end
      end
      default: begin
`ifdef KEYPAD_AUTOREPEAT_EN
        m_rep++;
        if (m_rep == RP) begin
          m_rep = 0;
          if (!rs[m_kr]) m_valid = 1;
        end
`endif
        if (rs[m_kr]) begin
          m_rel++;
          if (m_rel == DB) begin
            m_held = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4;
          end
        end else m_rel = 0;
      end
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // what: 0 = key_valid pulse, 1 = key_held low, 2 = col newly equal to arg.
  task automatic wait_until(input string name, input int what, input logic [3:0] arg, input int maxc);
    bit ok;
    logic [3:0] prev;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      prev = col;
      step(1);
      case (what)
        0:       ok = (key_valid === 1'b1);
        1:       ok = (key_held === 1'b0);
        default: ok = (col === arg) && (prev !== arg);
      endcase
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int base, extra, k1, k2, sel;
    fork
      forever begin
        @(posedge clk);
        model_edge();
        live = 1;
        @(negedge clk);
        if (live) begin
          check("cycle{col,code,valid,held}", {22'd0, col, key_code, key_valid, key_held},
                {22'd0, ~(4'b0001 << m_col), 4'(m_code), m_valid, m_held});
          if (key_valid === 1'b1) pulses++;
        end
      end
    join_none

    // Reset state and first full dwell.
    rst = 1'b0; pressed = '0;
    step(2);
    rst = 1'b1;
    check("rst_col", 32'(col), 32'hE);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    step(3);
    check("dwell_col_before", 32'(col), 32'hE);
    step(1);
    check("dwell_col_after", 32'(col), 32'hD);

    // Key 10 (row 2, column 2): one pulse, held, release advances to column 3.
    base = pulses;
    pressed = 16'd1 << 10;
    wait_until("k10_valid_timeout", 0, 4'h0, 80);
    check("k10_code", 32'(key_code), 32'd10);
    check("k10_held", 32'(key_held), 32'd1);
    check("k10_pulses", 32'(pulses - base), 32'd1);
    step(16);
    check("k10_still_held", 32'(key_held), 32'd1);
    check("k10_single_pulse", 32'(pulses - base), 32'd1);
    pressed = '0;
    wait_until("k10_release_timeout", 1, 4'h0, 40);
    check("k10_release_col", 32'(col), 32'h7);

    // Bounce on row 1 / column 0 for two samples only.
    wait_until("bounce_sync_timeout", 2, 4'hE, 30);
    base = pulses;
    pressed = 16'd1 << 4;
    step(8);
    check("bounce_col_frozen", 32'(col), 32'hE);
    pressed = '0;
    step(4);
    check("bounce_col_resume", 32'(col), 32'hD);
    check("bounce_no_pulse", 32'(pulses - base), 32'd0);
    check("bounce_not_held", 32'(key_held), 32'd0);

    // Rows 3 and 0 on column 3: row 0 wins; other keys ignored while held.
    base = pulses;
    pressed = (16'd1 << 15) | (16'd1 << 3);
    wait_until("multi_valid_timeout", 0, 4'h0, 80);
    check("multi_code", 32'(key_code), 32'd3);
    pressed = pressed | (16'd1 << 7);
    step(20);
    check("multi_ignore_other", 32'(pulses - base), 32'd1);
    pressed = (16'd1 << 15) | (16'd1 << 7);
    wait_until("multi_release_timeout", 1, 4'h0, 40);
    check("multi_no_new_pulse", 32'(pulses - base), 32'd1);
    pressed = '0;
    step(4);

    // Reset in the middle of confirmation after two matches.
    wait_until("rstconf_sync_timeout", 2, 4'hE, 30);
    base = pulses;
    pressed = 16'd1 << 8;
    step(8);
    check("rstconf_col_frozen", 32'(col), 32'hE);
    rst = 1'b0;
    step(2);
    check("rstconf_col", 32'(col), 32'hE);
    check("rstconf_code", 32'(key_code), 32'd0);
    check("rstconf_valid", 32'(key_valid), 32'd0);
    check("rstconf_held", 32'(key_held), 32'd0);
    rst = 1'b1;
    pressed = '0;
    step(4);
    check("rstconf_no_pulse", 32'(pulses - base), 32'd0);

    // Key 5 held for 12 sample points after acceptance.
    pressed = 16'd1 << 5;
    wait_until("k5_valid_timeout", 0, 4'h0, 80);
    check("k5_code", 32'(key_code), 32'd5);
    base = pulses;
`ifdef KEYPAD_AUTOREPEAT_EN
    extra = 2;
`else
    extra = 0;
`endif
    step(12 * SD);
    check("k5_repeat_pulses", 32'(pulses - base), 32'(extra));
    check("k5_code_kept", 32'(key_code), 32'd5);
    pressed = '0;
    wait_until("k5_release_timeout", 1, 4'h0, 40);

    // Randomized presses, multi-key chords and resets; the model checks every cycle.
    for (int it = 0; it < 40; it++) begin
      k1 = int'($urandom_range(0, 15));
      k2 = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      pressed = '0;
      else if (sel < 8) pressed = 16'd1 << k1;
      else              pressed = (16'd1 << k1) | (16'd1 << k2);
      step(int'($urandom_range(1, 100)));
      if (sel == 9) begin
        rst = 1'b0;
        step(int'($urandom_range(1, 2)));
        rst = 1'b1;
      end
    end
    pressed = '0;
    step(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
